pipereg: RTL

PIPEREG -- requirements
Module: pipereg

---
 rtl/pipereg.sv | 101 ++++++++++
 1 files changed

// File: rtl/pipereg.sv
// pipereg: one-deep valid/ready pipeline register with flush; define PIPEREG_SKID_EN
// to add a skid entry that registers in_ready and breaks the out_ready->in_ready path.
module pipereg #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] NOP   = '0
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             flushed_o,
    output logic [1:0]       occupancy_o
);
    logic             kill, accept, consume;
    logic             main_v_q, main_v_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             flushed_q;

    assign kill        = ~reset_ni | flush_i;
    assign accept      = in_valid_i & in_ready_o;
    assign consume     = main_v_q & out_ready_i;
    assign out_valid_o = main_v_q;
    assign out_data_o  = main_data_q;
    assign flushed_o   = flushed_q;

`ifdef PIPEREG_SKID_EN
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             rdy_q, rdy_d;

    // rdy_q mirrors "skid empty"; only reset/flush gate it combinationally
    assign in_ready_o  = rdy_q & ~kill;
    assign occupancy_o = {1'b0, main_v_q} + {1'b0, skid_v_q};

    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        if (kill) begin
            main_v_d    = 1'b0;
            main_data_d = NOP;
            skid_v_d    = 1'b0;
            skid_data_d = NOP;
        end else if (consume) begin
            if (skid_v_q) begin
                main_data_d = skid_data_q;
                skid_v_d    = 1'b0;
                skid_data_d = NOP;
            end else begin
                main_v_d    = accept;
                main_data_d = accept ? in_data_i : NOP;
            end
        end else if (accept) begin
            if (main_v_q) begin
                skid_v_d    = 1'b1;
                skid_data_d = in_data_i;
            end else begin
                main_v_d    = 1'b1;
                main_data_d = in_data_i;
            end
        end
        rdy_d = ~skid_v_d;
    end

    always_ff @(posedge clk_i) begin
        main_v_q    <= main_v_d;
        main_data_q <= main_data_d;
        skid_v_q    <= skid_v_d;
        skid_data_q <= skid_data_d;
        rdy_q       <= rdy_d;
        flushed_q   <= kill;
    end
`else
    assign in_ready_o  = ~kill & (out_ready_i | ~main_v_q);
    assign occupancy_o = {1'b0, main_v_q};

    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        if (kill || (consume && !accept)) begin
            main_v_d    = 1'b0;
            main_data_d = NOP;
        end else if (accept) begin
            main_v_d    = 1'b1;
            main_data_d = in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        main_v_q    <= main_v_d;
        main_data_q <= main_data_d;
        flushed_q   <= kill;
    end
`endif
endmodule
